// File: rtl/bus_target_pkg.sv
// bus_target shared definitions: FSM encodings and bus defaults.
// Imported by the register bank and the bus-side responder.
package bus_target_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/bus_target_regs.sv
// Generic register bank: one write port, combinational read mux,
// flattened parallel export of every register.
module bus_target_regs
  import bus_target_pkg::*;
#(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [IDX_W-1:0]               idx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic                  hit;

  // Guards non-power-of-two banks against stray indices.
  assign hit = {1'b0, idx} < N_L;

  always_comb begin
    regs_d = regs_q;
    if (we && hit) begin
      regs_d[idx] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata = hit ? regs_q[idx] : '0;

  for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: rtl/bus_target.sv
// Host-bus device responder: captures an access, inserts wait states,
// commits the write or returns read data with a one-cycle ready pulse.
module bus_target
  import bus_target_pkg::*;
#(
  parameter int unsigned DEVICE_ADDR_WIDTH = 14,
  parameter int unsigned DATA_WIDTH        = DEFAULT_DATA_WIDTH,
  parameter int unsigned NUM_REGS          = 8,
  parameter int unsigned WAIT_CYCLES       = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cs_n,
  input  logic                           we_n,
  input  logic                           oe_n,
  input  logic [DEVICE_ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]          data_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           data_oe,
  output logic                           ready,
  output logic                           err,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int unsigned AW    = DEVICE_ADDR_WIDTH;
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [AW:0] N_L   = (AW + 1)'(NUM_REGS);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

  logic                  start;
  logic                  go;
  logic                  unmapped;
  logic [AW-1:0]         acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_wr;
  logic                  reg_we;
  logic [DATA_WIDTH-1:0] reg_rdata;

  assign start = !cs_n && (!we_n || !oe_n);

  // Zero wait states commit straight from the bus on the capture edge.
  assign acc_addr  = (state_q == S_IDLE) ? address : addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? data_in : wdata_q;
  assign acc_wr    = (state_q == S_IDLE) ? !we_n   : wr_q;
  assign unmapped  = {1'b0, acc_addr} >= N_L;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    dout_d  = dout_q;
    oe_d    = oe_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    go      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = address;
          wdata_d = data_in;
          wr_d    = !we_n;
          if (WAIT_CYCLES == 0) begin
            go = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cs_n) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          go = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACCESS: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cs_n) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q == S_ACCESS || state_q == S_HOLD) && (cs_n || oe_n)) begin
      oe_d = 1'b0;
    end

    if (go) begin
      state_d = S_ACCESS;
      ready_d = 1'b1;
      err_d   = unmapped;
      if (!acc_wr) begin
        dout_d = unmapped ? '0 : reg_rdata;
        oe_d   = 1'b1;
      end
    end
  end

  assign reg_we = go && acc_wr && !unmapped;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  bus_target_regs #(
    .NUM_REGS  (NUM_REGS),
    .DATA_WIDTH(DATA_WIDTH),
    .IDX_W     (IDX_W)
  ) u_regs (
    .clk     (clk),
    .reset   (reset),
    .we      (reg_we),
    .idx     (acc_addr[IDX_W-1:0]),
    .wdata   (acc_wdata),
    .rdata   (reg_rdata),
    .regs_out(regs_out)
  );

  assign data_out = dout_q;
  assign data_oe  = oe_q;
  assign ready    = ready_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bus_target.sv
// Directed scoreboard bench for bus_target: one instance with two wait
// states, one with zero wait states sharing all inputs but chip select.
module tb_bus_target;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int NR = 8;
  localparam int RW = NR * DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cs_n = 1'b1;
  logic          cs0_n = 1'b1;
  logic          we_n = 1'b1;
  logic          oe_n = 1'b1;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] data_out, data_out0;
  logic          data_oe, data_oe0;
  logic          ready, ready0;
  logic          err, err0;
  logic [RW-1:0] regs_out, regs_out0;

  always #5 clk = ~clk;

  bus_target #(
    .DEVICE_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_REGS(NR), .WAIT_CYCLES(2)
  ) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .we_n(we_n),
    .oe_n(oe_n), .address(address), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .ready(ready),
    .err(err), .regs_out(regs_out)
  );

  bus_target #(
    .DEVICE_ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_REGS(NR), .WAIT_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset(reset), .cs_n(cs0_n), .we_n(we_n),
    .oe_n(oe_n), .address(address), .data_in(data_in),
    .data_out(data_out0), .data_oe(data_oe0), .ready(ready0),
    .err(err0), .regs_out(regs_out0)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          rd;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] m2 [NR];
  logic [DW-1:0] m0 [NR];
  int            ncmp = 0;
  int            nbad = 0;

  bit            sel = 1'b0;
  logic          o_ready, o_err, o_oe;
  logic [DW-1:0] o_dout;
  logic [RW-1:0] o_regs;

  always_comb begin
    o_ready = sel ? ready0    : ready;
    o_err   = sel ? err0      : err;
    o_oe    = sel ? data_oe0  : data_oe;
    o_dout  = sel ? data_out0 : data_out;
    o_regs  = sel ? regs_out0 : regs_out;
  end

  task automatic chk(input string tag, input logic [RW-1:0] obs,
                     input logic [RW-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] flat(input bit s);
    logic [RW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = s ? m0[i] : m2[i];
    return v;
  endfunction

  task automatic access(input bit s, input bit wr, input bit rd,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit hold_extra);
    exp_t e;
    int   n;
    int   lat;
    bit   mapped;
    lat    = s ? 0 : 2;
    mapped = (a < AW'(NR));
    e.rd   = rd && !wr;
    e.err  = !mapped;
    e.rdata = '0;
    if (mapped) e.rdata = s ? m0[a[2:0]] : m2[a[2:0]];
    if (wr && mapped) begin
      if (s) m0[a[2:0]] = d;
      else   m2[a[2:0]] = d;
    end
    sb.push_back(e);
    sel = s;
    @(negedge clk);
    if (s) cs0_n = 1'b0;
    else   cs_n  = 1'b0;
    we_n = !wr; oe_n = !rd; address = a; data_in = d;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk("ready_latency", RW'(n), RW'(lat));
    e = sb.pop_front();
    chk("err", RW'(o_err), RW'(e.err));
    chk("data_oe", RW'(o_oe), RW'(e.rd));
    if (e.rd) chk("data_out", RW'(o_dout), RW'(e.rdata));
    chk("regs_out", o_regs, flat(s));
    @(negedge clk);
    chk("ready_pulse", RW'(o_ready), RW'(1'b0));
    chk("err_pulse", RW'(o_err), RW'(1'b0));
    chk("hold_oe", RW'(o_oe), RW'(e.rd));
    if (hold_extra) begin
      @(negedge clk);
      chk("hold_oe2", RW'(o_oe), RW'(e.rd));
    end
    cs_n = 1'b1; cs0_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);
    chk("oe_drop", RW'(o_oe), RW'(1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    for (int i = 0; i < NR; i++) begin
      m2[i] = '0;
      m0[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", RW'(ready), RW'(1'b0));
    chk("rst_oe", RW'(data_oe), RW'(1'b0));
    chk("rst_dout", RW'(data_out), RW'(0));
    chk("rst_regs", regs_out, RW'(0));
    chk("rst_regs0", regs_out0, RW'(0));
    reset = 1'b0;

    access(0, 1, 0, 14'd3, 16'hA5A5, 0);
    access(0, 0, 1, 14'd3, 16'h0000, 1);
    access(0, 1, 0, 14'd8, 16'h1234, 0);
    access(0, 0, 1, 14'd8, 16'h0000, 0);

    // Abort: start a write, drop chip select while waiting.
    sel = 1'b0;
    @(negedge clk);
    cs_n = 1'b0; we_n = 1'b0; address = 14'd1; data_in = 16'hFFFF;
    @(negedge clk);
    seen = ready || err;
    cs_n = 1'b1; we_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (ready || err) seen = 1'b1;
    end
    chk("abort_no_ready", RW'(seen), RW'(1'b0));
    chk("abort_regs", regs_out, flat(0));
    chk("abort_state", RW'(dut.state_q), RW'(0));

    access(0, 1, 1, 14'd2, 16'h5A5A, 0);
    access(0, 0, 1, 14'd3, 16'h0000, 0);

    // Reset while a write sits in its wait states.
    @(negedge clk);
    cs_n = 1'b0; we_n = 1'b0; address = 14'd5; data_in = 16'h7777;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NR; i++) m2[i] = '0;
    chk("mid_rst_ready", RW'(ready), RW'(1'b0));
    chk("mid_rst_err", RW'(err), RW'(1'b0));
    chk("mid_rst_oe", RW'(data_oe), RW'(1'b0));
    chk("mid_rst_dout", RW'(data_out), RW'(0));
    chk("mid_rst_regs", regs_out, flat(0));
    chk("mid_rst_state", RW'(dut.state_q), RW'(0));
    reset = 1'b0; cs_n = 1'b1; we_n = 1'b1;

    access(1, 1, 0, 14'd6, 16'hBEEF, 0);
    access(1, 0, 1, 14'd6, 16'h0000, 0);
    access(1, 0, 1, 14'd9, 16'h0000, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/bus_target.md
# bus_target

Device-side responder for the FPGA host bus: it sits behind one active-low chip-select line from the address decoder and serves a bank of NUM_REGS read/write registers. It captures a master access, inserts a programmable number of wait states, then commits the write or drives read data with a one-cycle ready pulse. Register contents are exported in parallel to user logic.

## Interface
- DEVICE_ADDR_WIDTH, 14: width of the device-local address (the decoder strips the bus-select bits).
- DATA_WIDTH, 16: bus data width.
- NUM_REGS, 8: number of registers, 1..2^DEVICE_ADDR_WIDTH.
- WAIT_CYCLES, 2: wait states between capture and access, 0..15.

Ports:
- clk  input  1  system clock; every other input is synchronous to it.
- reset  input  1  synchronous, active-high reset.
- cs_n  input  1  chip select from the decoder output for this device, active low.
- we_n  input  1  write strobe, active low.
- oe_n  input  1  read (output-enable) strobe, active low.
- address  input  DEVICE_ADDR_WIDTH  device-local word address.
- data_in  input  DATA_WIDTH  write data from the master.
- data_out  output  DATA_WIDTH  read data to the master.
- data_oe  output  1  high while data_out must be driven onto the shared bus.
- ready  output  1  one-cycle pulse marking access completion.
- err  output  1  one-cycle pulse, coincident with ready, when the access hit an unmapped address.
- regs_out  output  NUM_REGS*DATA_WIDTH  register bank; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- States: IDLE, WAIT, ACCESS, HOLD.
- IDLE -> start when, at a rising edge, cs_n=0 and (we_n=0 or oe_n=0). At that edge the block latches address, data_in and the operation. If both strobes are low, the operation is a write.
- Start -> WAIT with the counter loaded to WAIT_CYCLES-1. If WAIT_CYCLES=0, start goes directly to ACCESS.
- WAIT: the counter decrements each cycle; the state moves to ACCESS on the edge where the counter equals 0.
- Entering ACCESS, the access is performed from the latched values:
  - Write to a mapped address: the register is updated.
  - Read from a mapped address: data_out is loaded with the register value.
  - Unmapped address (address >= NUM_REGS): the write is dropped, or the read loads data_out with 0.
- ACCESS lasts exactly one cycle, with ready=1 (and err=1 if unmapped), then moves to HOLD.
- HOLD: waits for cs_n=1, then returns to IDLE. A new access requires cs_n to deassert first; back-to-back accesses with cs_n held low are not supported.
- Abort: if cs_n=1 is sampled in WAIT, the block returns to IDLE with no register update, no ready and no err.
- data_oe is 1 from the ACCESS cycle through HOLD for read operations only. It drops on the edge where cs_n=1 or oe_n=1 is sampled. data_out holds its last value.
- Reset overrides everything, including a transaction in flight: state=IDLE, all registers 0, data_out=0, data_oe=0, ready=0, err=0, counter=0.
- Address compare is unsigned at full DEVICE_ADDR_WIDTH. There is no aliasing of upper address bits.

## Timing
- Start sampled at edge k: ready is high in the cycle after edge k+WAIT_CYCLES.
- WAIT_CYCLES=2 gives ready one cycle after edge k+2. WAIT_CYCLES=0 gives ready one cycle after edge k, with capture and commit on the same edge.
- A write is visible on regs_out in the same cycle as ready.
- A read: data_out is valid and data_oe=1 in the ready cycle.
- HOLD exits to IDLE one edge after cs_n=1 is sampled. The earliest next start is at the following edge.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- The shared include holds the state encodings (2-bit: IDLE=0, WAIT=1, ACCESS=2, HOLD=3) and the default data width.
- Sub-module bus_target_regs: the register bank with write-enable, index and write-data ports, a combinational read mux and the flattened regs_out. It is shared with future peripherals.
- The FSM, wait counter and bus-side registers live in bus_target.

## Test plan
- Write: reset, then cs_n=0, we_n=0, address=3, data_in=16'hA5A5 at edge k. Required: ready=1 exactly one cycle, in the cycle after edge k+2; regs_out slice 3 = 16'hA5A5; all other slices 0.
- Read-back: after the write above, cs_n=0, oe_n=0, address=3. Required: data_out=16'hA5A5 with data_oe=1 in the ready cycle. data_oe stays high until cs_n=1 is sampled, then drops.
- Unmapped access: write 16'h1234 to address 8, then read address 8. Required: err coincides with ready both times; the read returns 0; no register changes.
- Abort: start a write to address 1, then raise cs_n one cycle later (during WAIT). Required: no ready, no err; register 1 unchanged; state back in IDLE.
- Reset mid-transaction and zero wait: assert reset in WAIT. Required: all outputs 0 and all registers 0 next cycle. Then, with WAIT_CYCLES=0, a write is followed by ready in the cycle after the start edge.
- Simultaneous strobes: we_n=0 and oe_n=0 together. Required: treated as a write, data_oe stays 0.
